lfsr_rand_gen: RTL and testbench

LFSR_RAND_GEN -- requirements
Module: lfsr_rand_gen

---
 rtl/lfsr_pkg.sv | 26 ++
 rtl/lfsr_core.sv | 42 ++++
 rtl/lfsr_rand_gen.sv | 106 ++++++++++
 tb/tb_lfsr_rand_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types, default Galois tap masks and helpers for the LFSR random generator.
package lfsr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } lfsr_state_e;

    // Galois masks: bit i set for each x^i term below the leading power.
    localparam logic [7:0]  LFSR_TAPS_8  = 8'h71;         // x^8+x^6+x^5+x^4+1
    localparam logic [15:0] LFSR_TAPS_16 = 16'h002D;      // x^16+x^5+x^3+x^2+1
    localparam logic [31:0] LFSR_TAPS_32 = 32'h0040_0007; // x^32+x^22+x^2+x+1

    // (smallest power of two >= limit) - 1, for limit >= 1.
    function automatic logic [31:0] lfsr_pow2_mask(input logic [31:0] limit);
        logic [31:0] m;
        m = limit - 32'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register with runtime seed load and all-zero lockup recovery.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_16),
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load beats lockup recovery, which beats a normal step.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = (seed_i == '0) ? SEED : seed_i;
        end else if (q_q == '0) begin
            q_d = SEED;
        end else if (step_i) begin
            q_d = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// LFSR generator with a bounded draw: rejection sampling below Limit, with a
// fold-back fallback after MAX_TRIES rejections so latency stays bounded.
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR_TAPS_16),
    parameter logic [WIDTH-1:0] SEED      = '1,
    parameter int unsigned      OUT_W     = 8,
    parameter int unsigned      MAX_TRIES = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             SeedLoad,
    input  logic [WIDTH-1:0] Seed,
    output logic [WIDTH-1:0] Q,
    input  logic             Req,
    input  logic [OUT_W-1:0] Limit,
    output logic             Busy,
    output logic             Valid,
    output logic [OUT_W-1:0] Value
);

    localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    lfsr_state_e      state_q;
    logic [OUT_W-1:0] limit_q;
    logic [OUT_W-1:0] mask_q;
    logic [TRY_W-1:0] try_q;
    logic             valid_q;
    logic [OUT_W-1:0] value_q;

    logic [OUT_W-1:0] cand_c;
    logic             reject_c;
    logic             last_try_c;

    always_comb begin
        cand_c     = Q[OUT_W-1:0] & mask_q;
        reject_c   = (state_q == ST_DRAW) && (cand_c >= limit_q);
        last_try_c = (try_q == TRY_W'(MAX_TRIES - 1));
    end

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .step_i (Enable | reject_c),
        .load_i (SeedLoad),
        .seed_i (Seed),
        .q_o    (Q)
    );

    // Draw FSM; the core steps on every rejection so the next candidate is fresh.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            mask_q  <= '0;
            try_q   <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Req) begin
                        if (Limit == '0) begin
                            valid_q <= 1'b1;
                            value_q <= '0;
                        end else begin
                            limit_q <= Limit;
                            mask_q  <= OUT_W'(lfsr_pow2_mask(32'(Limit)));
                            try_q   <= '0;
                            state_q <= ST_DRAW;
                        end
                    end
                end
                ST_DRAW: begin
                    if (!reject_c) begin
                        value_q <= cand_c;
                        valid_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (last_try_c) begin
                        // mask < 2*limit, so the folded value is always in range.
                        value_q <= cand_c - limit_q;
                        valid_q <= 1'b1;
                        try_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        try_q <= try_q + TRY_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy  = (state_q == ST_DRAW);
    assign Valid = valid_q;
    assign Value = value_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench for lfsr_rand_gen: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_lfsr_rand_gen;

    localparam int unsigned MT = 16;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Enable;
    logic        SeedLoad;
    logic [15:0] Seed;
    logic        Req;
    logic [7:0]  Limit;
    logic [15:0] Q,     Q1;
    logic        Busy,  Busy1;
    logic        Valid, Valid1;
    logic [7:0]  Value, Value1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    int unsigned m_q, m_limit, m_pow, m_tries, m_value;
    bit          m_busy, m_valid;

    always #5 Clk = ~Clk;

    lfsr_rand_gen dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .SeedLoad(SeedLoad), .Seed(Seed),
        .Q(Q), .Req(Req), .Limit(Limit), .Busy(Busy), .Valid(Valid), .Value(Value)
    );

    lfsr_rand_gen #(.MAX_TRIES(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .SeedLoad(SeedLoad), .Seed(Seed),
        .Q(Q1), .Req(Req), .Limit(Limit), .Busy(Busy1), .Valid(Valid1), .Value(Value1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned lfsr_next(input int unsigned q);
        return ((q * 2) % 65536) ^ ((q >= 32768) ? 32'h2D : 32'h0);
    endfunction

    function automatic int unsigned ceil_pow2(input int unsigned n);
        int unsigned p = 1;
        while (p < n) p = p * 2;
        return p;
    endfunction

    task automatic model_reset();
        m_q = 32'hFFFF; m_busy = 1'b0; m_valid = 1'b0; m_value = 0;
        m_tries = 0; m_limit = 0; m_pow = 1;
    endtask

    // One clock edge of the reference, using the input values held across it.
    task automatic model_edge();
        int unsigned cand, nval;
        bit nv, rej;
        cand = (m_q % 256) % m_pow;
        rej  = m_busy && (cand >= m_limit);
        nv = 1'b0; nval = 0;
        if (!m_busy) begin
            if (Req) begin
                if (Limit == 8'd0) nv = 1'b1;
                else begin
                    m_busy = 1'b1; m_limit = 32'(Limit);
                    m_pow = ceil_pow2(32'(Limit)); m_tries = 0;
                end
            end
        end else if (!rej) begin
            nv = 1'b1; nval = cand; m_busy = 1'b0;
        end else begin
            m_tries++;
            if (m_tries == MT) begin
                nv = 1'b1; nval = cand - m_limit; m_busy = 1'b0;
            end
        end
        if (SeedLoad)              m_q = (Seed == 16'd0) ? 32'hFFFF : 32'(Seed);
        else if (m_q == 0)         m_q = 32'hFFFF;
        else if (Enable || rej)    m_q = lfsr_next(m_q);
        m_valid = nv;
        if (nv) m_value = nval;
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (Rst) model_reset();
        else     model_edge();
        #1;
        check_eq("q",     32'(Q),     m_q);
        check_eq("busy",  32'(Busy),  32'(m_busy));
        check_eq("valid", 32'(Valid), 32'(m_valid));
        check_eq("value", 32'(Value), m_value);
    endtask

    // Asserts Rst between edges and checks the asynchronous effect before any edge.
    task automatic reset_pulse();
        #1;
        Rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_q",     32'(Q),     32'hFFFF);
        check_eq("rst_busy",  32'(Busy),  0);
        check_eq("rst_valid", 32'(Valid), 0);
        check_eq("rst_value", 32'(Value), 0);
        cycle();
        Rst = 1'b0;
    endtask

    task automatic idle_inputs();
        Enable = 1'b0; SeedLoad = 1'b0; Seed = 16'd0; Req = 1'b0; Limit = 8'd0;
    endtask

    initial begin
        int unsigned first_ret, zero_seen;
        Rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        check_eq("init_q",     32'(Q),     32'hFFFF);
        check_eq("init_valid", 32'(Valid), 0);
        cycle();
        Rst = 1'b0;

        // Two steps from the seed.
        Enable = 1'b1;
        cycle(); check_eq("step1", 32'(Q), 32'hFFD3);
        cycle(); check_eq("step2", 32'(Q), 32'hFF8B);

        // Full period from all-ones.
        reset_pulse();
        Enable = 1'b1;
        first_ret = 0; zero_seen = 0;
        for (int i = 1; i <= 65535; i++) begin
            cycle();
            if (Q == 16'h0000) zero_seen++;
            if (Q == 16'hFFFF && first_ret == 0) first_ret = i;
        end
        check_eq("period",    first_ret, 65535);
        check_eq("zero_seen", zero_seen, 0);

        // One rejection then accept: Q=FFFF, Limit=10.
        reset_pulse();
        idle_inputs();
        Req = 1'b1; Limit = 8'd10;
        cycle(); Req = 1'b0;
        check_eq("rej_busy", 32'(Busy), 1);
        cycle();
        check_eq("rej_q",     32'(Q),     32'hFFD3);
        check_eq("rej_valid", 32'(Valid), 0);
        cycle();
        check_eq("rej_valid2", 32'(Valid), 1);
        check_eq("rej_value",  32'(Value), 3);
        check_eq("rej_busy2",  32'(Busy),  0);
        cycle();
        check_eq("rej_pulse", 32'(Valid), 0);

        // Immediate accept from FFD3.
        Req = 1'b1; Limit = 8'd10;
        cycle(); Req = 1'b0;
        check_eq("acc_busy", 32'(Busy), 1);
        cycle();
        check_eq("acc_valid", 32'(Valid), 1);
        check_eq("acc_value", 32'(Value), 3);
        check_eq("acc_busy2", 32'(Busy),  0);

        // Seed loads and zero-limit draw.
        SeedLoad = 1'b1; Seed = 16'h1234;
        cycle(); check_eq("seed_load", 32'(Q), 32'h1234);
        Seed = 16'h0000;
        cycle(); check_eq("seed_zero", 32'(Q), 32'hFFFF);
        SeedLoad = 1'b0; Req = 1'b1; Limit = 8'd0;
        cycle(); Req = 1'b0;
        check_eq("lim0_valid", 32'(Valid), 1);
        check_eq("lim0_value", 32'(Value), 0);
        check_eq("lim0_busy",  32'(Busy),  0);
        cycle();
        check_eq("lim0_pulse", 32'(Valid), 0);

        // Forced fallback with a single allowed try.
        reset_pulse();
        Req = 1'b1; Limit = 8'd10;
        cycle(); Req = 1'b0;
        check_eq("mt1_busy", 32'(Busy1), 1);
        cycle();
        check_eq("mt1_valid", 32'(Valid1), 1);
        check_eq("mt1_value", 32'(Value1), 5);
        check_eq("mt1_busy2", 32'(Busy1),  0);

        // Reset mid-draw aborts without a result.
        reset_pulse();
        Req = 1'b1; Limit = 8'd10;
        cycle(); Req = 1'b0;
        check_eq("abort_busy", 32'(Busy), 1);
        reset_pulse();
        cycle();
        check_eq("abort_valid", 32'(Valid), 0);
        check_eq("abort_q",     32'(Q),     32'hFFFF);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            Enable   = ($urandom_range(0, 1) == 1);
            Req      = ($urandom_range(0, 2) == 0);
            Limit    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20))
                                                   : 8'($urandom_range(0, 255));
            SeedLoad = ($urandom_range(0, 29) == 0);
            Seed     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
            if (i % 500 == 499) reset_pulse();
            else                cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
